// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM states and
// a one-hot helper used to build the grant vector.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning upward from
// (last+1) with wrap-around.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               valid,
  output logic [SEL_W-1:0]   winner
);

  logic [SEL_W-1:0] idx;

  // Walk the scan order backwards so the nearest requester after last wins.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = last + SEL_W'(i + 1);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter in front of a shared resource with a
// start/ready/done handshake and a transaction timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no grant; pick next winner when any request is pending
//   REQ     | grant held, res_start high, waiting for res_ready
//   WAIT    | accepted by resource, waiting for res_done (no abort)
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               res_start,
  input  logic               res_ready,
  input  logic               res_done,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_winner;

  logic done_ok;
  logic abandon;
  logic tmo_hit;
  logic retire;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Completion beats timeout; an abandoned request retires without credit.
  always_comb begin
    done_ok = 1'b0;
    abandon = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      ST_REQ: begin
        done_ok = res_ready && res_done;
        abandon = !res_ready && !req[sel];
      end
      ST_WAIT: done_ok = res_done;
      default: ;
    endcase
    if (state != ST_IDLE && cnt == CNT_W'(TIMEOUT - 1) && !done_ok && !abandon)
      tmo_hit = 1'b1;
    retire = done_ok || abandon || tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      sel         <= '0;
      res_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last        <= SEL_W'(NUM_REQ - 1);
    end else begin
      timeout_err <= 1'b0;
      if (state == ST_IDLE) begin
        if (pick_valid) begin
          state     <= ST_REQ;
          grant     <= onehot(pick_winner);
          sel       <= pick_winner;
          res_start <= 1'b1;
          busy      <= 1'b1;
          cnt       <= '0;
        end
      end else if (retire) begin
        state       <= ST_IDLE;
        grant       <= '0;
        res_start   <= 1'b0;
        busy        <= 1'b0;
        cnt         <= '0;
        timeout_err <= tmo_hit;
        if (!abandon) last <= sel;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == ST_REQ && res_ready) begin
          state     <= ST_WAIT;
          res_start <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: default-timeout instance for arbitration and
// handshake, a TIMEOUT=4 instance for retirement cases.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] req, grant;
  logic [1:0] sel;
  logic       res_start, res_ready, res_done, busy, timeout_err;

  logic [3:0] b_req, b_grant;
  logic [1:0] b_sel;
  logic       b_res_start, b_res_ready, b_res_done, b_busy, b_timeout_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter4 u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .sel         (sel),
    .res_start   (res_start),
    .res_ready   (res_ready),
    .res_done    (res_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  rr_arbiter4 #(.TIMEOUT(4), .CNT_W(8)) u_dut_tmo (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (b_req),
    .grant       (b_grant),
    .sel         (b_sel),
    .res_start   (b_res_start),
    .res_ready   (b_res_ready),
    .res_done    (b_res_done),
    .busy        (b_busy),
    .timeout_err (b_timeout_err)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; res_ready = 1'b0; res_done = 1'b0;
    b_req = '0; b_res_ready = 1'b0; b_res_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_rr [10];

  initial begin
    exp_rr = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    // reset state
    do_reset();
    chk("rst_grant", {4'b0, grant}, 8'h00);
    chk("rst_sel",   {6'b0, sel}, 8'h00);
    chk("rst_start", {7'b0, res_start}, 8'h00);
    chk("rst_busy",  {7'b0, busy}, 8'h00);
    chk("rst_terr",  {7'b0, timeout_err}, 8'h00);

    // rotation with zero-wait completion
    req = 4'b1111; res_ready = 1'b1; res_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), {4'b0, grant}, {4'b0, exp_rr[i]});
      chk($sformatf("rr_busy%0d", i), {7'b0, busy}, {7'b0, |exp_rr[i]});
    end

    // single request with handshake latency
    do_reset();
    req = 4'b0100;
    tick();
    chk("hs_grant", {4'b0, grant}, 8'h04);
    chk("hs_sel",   {6'b0, sel}, 8'h02);
    chk("hs_start", {7'b0, res_start}, 8'h01);
    chk("hs_busy",  {7'b0, busy}, 8'h01);
    tick();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_wait_start", {7'b0, res_start}, 8'h00);
    chk("hs_wait_grant", {4'b0, grant}, 8'h04);
    tick();
    tick();
    res_done = 1'b1;
    tick();
    res_done = 1'b0;
    req = '0;
    chk("hs_done_grant", {4'b0, grant}, 8'h00);
    chk("hs_done_busy",  {7'b0, busy}, 8'h00);
    tick();
    chk("hs_sel_hold", {6'b0, sel}, 8'h02);
    chk("hs_idle_grant", {4'b0, grant}, 8'h00);

    // abandon in REQ keeps last
    do_reset();
    req = 4'b0010;
    tick();
    chk("ab_grant", {4'b0, grant}, 8'h02);
    req = 4'b0000;
    tick();
    chk("ab_idle_grant", {4'b0, grant}, 8'h00);
    chk("ab_idle_busy",  {7'b0, busy}, 8'h00);
    req = 4'b1010;
    tick();
    chk("ab_regrant", {4'b0, grant}, 8'h02);
    chk("ab_regrant_sel", {6'b0, sel}, 8'h01);
    res_ready = 1'b1; res_done = 1'b1;
    tick();
    res_ready = 1'b0; res_done = 1'b0; req = '0;
    chk("ab_done_grant", {4'b0, grant}, 8'h00);

    // timeout on the TIMEOUT=4 instance
    do_reset();
    b_req = 4'b1000;
    tick();
    chk("to_grant", {4'b0, b_grant}, 8'h08);
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    chk("to_wait_start", {7'b0, b_res_start}, 8'h00);
    tick();
    tick();
    chk("to_pre_terr", {7'b0, b_timeout_err}, 8'h00);
    tick();
    chk("to_terr",  {7'b0, b_timeout_err}, 8'h01);
    chk("to_grant0", {4'b0, b_grant}, 8'h00);
    chk("to_busy0",  {7'b0, b_busy}, 8'h00);
    b_req = 4'b1001;
    tick();
    chk("to_terr_pulse", {7'b0, b_timeout_err}, 8'h00);
    chk("to_next_grant", {4'b0, b_grant}, 8'h01);
    chk("to_next_sel",   {6'b0, b_sel}, 8'h00);

    // done coincident with the timeout cycle
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    tick();
    tick();
    b_res_done = 1'b1;
    tick();
    b_res_done = 1'b0;
    chk("tc_grant0", {4'b0, b_grant}, 8'h00);
    chk("tc_terr",   {7'b0, b_timeout_err}, 8'h00);
    chk("tc_busy0",  {7'b0, b_busy}, 8'h00);
    tick();
    chk("tc_next_grant", {4'b0, b_grant}, 8'h08);
    chk("tc_terr2", {7'b0, b_timeout_err}, 8'h00);
    b_req = '0;

    // asynchronous reset during WAIT
    do_reset();
    req = 4'b0010;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ar_wait_busy", {7'b0, busy}, 8'h01);
    chk("ar_wait_grant", {4'b0, grant}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant0", {4'b0, grant}, 8'h00);
    chk("ar_busy0",  {7'b0, busy}, 8'h00);
    chk("ar_start0", {7'b0, res_start}, 8'h00);
    chk("ar_terr0",  {7'b0, timeout_err}, 8'h00);
    req = 4'b1000;
    tick();
    chk("ar_held_grant", {4'b0, grant}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("ar_post_grant", {4'b0, grant}, 8'h08);
    chk("ar_post_sel",   {6'b0, sel}, 8'h03);
    chk("ar_post_terr",  {7'b0, timeout_err}, 8'h00);
    req = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
